// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: fabric-side warm-boot controller.
// Synchronises the user design's boot request and range-checks the requested slot.
// Asks the bitstream loader to load that slot's base address.
// Holds the user fabric in reset during the load and for a guard window afterwards.
// Optional feature: define WARMBOOT_TIMEOUT_EN to add a LOAD watchdog and the
// timeout_o output.
module warmboot_ctrl #(
  parameter int NUM_SLOTS      = 16,
  parameter int SLOT_W         = 4,
  parameter int ADDR_W         = 24,
  parameter int SLOT_SIZE_LOG2 = 18,
  parameter int GUARD_CYCLES   = 16
`ifdef WARMBOOT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_i,
  input  logic [SLOT_W-1:0] slot_i,
  output logic              fabric_reset_o,
  output logic              cfg_req_o,
  output logic [ADDR_W-1:0] cfg_addr_o,
  input  logic              cfg_ack_i,
  input  logic              cfg_done_i,
  input  logic              cfg_err_i,
  output logic              busy_o,
  output logic [SLOT_W-1:0] last_slot_o,
  output logic              err_o
`ifdef WARMBOOT_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  typedef enum logic [1:0] {GUARD, IDLE, REQ, LOAD} state_t;

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD_CYCLES - 1);

  state_t            state, state_nxt;
  logic [GW-1:0]     guard_cnt, guard_cnt_nxt;
  logic              sync_ff, boot_s, boot_q;
  logic              rise;
  logic              pend, pend_nxt;
  logic [SLOT_W-1:0] slot_r, slot_nxt;
  logic [SLOT_W-1:0] last_slot, last_nxt;
  logic              err_r, err_nxt;

`ifdef WARMBOOT_TIMEOUT_EN
  logic [15:0]       wd_cnt, wd_nxt;
  logic              timeout_r, timeout_nxt;
`endif

  // A held request only counts once: the request must drop and then rise again.
  assign rise = boot_s & ~boot_q;

  // Two-flop synchroniser for the asynchronous request, plus the edge history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 1'b0;
      boot_s  <= 1'b0;
      boot_q  <= 1'b0;
    end else begin
      sync_ff <= boot_i;
      boot_s  <= sync_ff;
      boot_q  <= boot_s;
    end
  end

  // Controller state; reset lands in GUARD so the fabric is held after power-up too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= GUARD;
      guard_cnt <= GUARD_INIT;
      pend      <= 1'b0;
      slot_r    <= '0;
      last_slot <= '0;
      err_r     <= 1'b0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_cnt_nxt;
      pend      <= pend_nxt;
      slot_r    <= slot_nxt;
      last_slot <= last_nxt;
      err_r     <= err_nxt;
    end
  end

`ifdef WARMBOOT_TIMEOUT_EN
  // Watchdog counter for LOAD and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_r <= 1'b0;
    end else begin
      wd_cnt    <= wd_nxt;
      timeout_r <= timeout_nxt;
    end
  end

  assign timeout_o = timeout_r;
`endif

  // Next-state and output decode.
  // IDLE spends one cycle range-checking the latched slot before it issues a request.
  always_comb begin
    state_nxt      = state;
    guard_cnt_nxt  = guard_cnt;
    pend_nxt       = pend;
    slot_nxt       = slot_r;
    last_nxt       = last_slot;
    err_nxt        = err_r;
    fabric_reset_o = 1'b1;
    busy_o         = 1'b1;
    cfg_req_o      = 1'b0;
    cfg_addr_o     = '0;
`ifdef WARMBOOT_TIMEOUT_EN
    wd_nxt         = '0;
    timeout_nxt    = timeout_r;
`endif
    case (state)
      GUARD: begin
        if (guard_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          guard_cnt_nxt = guard_cnt - GW'(1);
        end
      end
      IDLE: begin
        fabric_reset_o = 1'b0;
        busy_o         = 1'b0;
        if (pend) begin
          pend_nxt = 1'b0;
          if (32'(slot_r) >= NUM_SLOTS) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = REQ;
          end
        end else if (rise) begin
          slot_nxt = slot_i;
          pend_nxt = 1'b1;
        end
      end
      REQ: begin
        cfg_req_o  = 1'b1;
        cfg_addr_o = ADDR_W'(slot_r) << SLOT_SIZE_LOG2;
        if (cfg_ack_i) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (cfg_err_i) begin
          err_nxt       = 1'b1;
          state_nxt     = GUARD;
          guard_cnt_nxt = GUARD_INIT;
        end else if (cfg_done_i) begin
          last_nxt      = slot_r;
          state_nxt     = GUARD;
          guard_cnt_nxt = GUARD_INIT;
        end
`ifdef WARMBOOT_TIMEOUT_EN
        else if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          err_nxt       = 1'b1;
          timeout_nxt   = 1'b1;
          state_nxt     = GUARD;
          guard_cnt_nxt = GUARD_INIT;
        end else begin
          wd_nxt = wd_cnt + 16'd1;
        end
`endif
      end
      default: begin
        state_nxt     = GUARD;
        guard_cnt_nxt = GUARD_INIT;
      end
    endcase
  end

  assign last_slot_o = last_slot;
  assign err_o       = err_r;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// tb_warmboot_ctrl: directed bench for warmboot_ctrl.
// A cycle-level behavioural model is checked against the DUT on every cycle.
// Hand-computed literal expectations pin the model itself.
module tb_warmboot_ctrl;

  localparam int NUM_SLOTS = 8;
  localparam int ADDR_W    = 24;
  localparam int SHIFT     = 18;
  localparam int GUARD     = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_i = 1'b0;
  logic [3:0]  slot_i = '0;
  logic        cfg_ack_i = 1'b0;
  logic        cfg_done_i = 1'b0;
  logic        cfg_err_i = 1'b0;
  logic        fabric_reset_o;
  logic        cfg_req_o;
  logic [23:0] cfg_addr_o;
  logic        busy_o;
  logic [3:0]  last_slot_o;
  logic        err_o;
`ifdef WARMBOOT_TIMEOUT_EN
  logic        timeout_o;
`endif

  int checks = 0;
  int passes = 0;
  bit sim_done = 1'b0;

  warmboot_ctrl #(
    .NUM_SLOTS      (NUM_SLOTS),
    .SLOT_W         (4),
    .ADDR_W         (ADDR_W),
    .SLOT_SIZE_LOG2 (SHIFT),
    .GUARD_CYCLES   (GUARD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .boot_i         (boot_i),
    .slot_i         (slot_i),
    .fabric_reset_o (fabric_reset_o),
    .cfg_req_o      (cfg_req_o),
    .cfg_addr_o     (cfg_addr_o),
    .cfg_ack_i      (cfg_ack_i),
    .cfg_done_i     (cfg_done_i),
    .cfg_err_i      (cfg_err_i),
    .busy_o         (busy_o),
    .last_slot_o    (last_slot_o),
    .err_o          (err_o)
`ifdef WARMBOOT_TIMEOUT_EN
    ,
    .timeout_o      (timeout_o)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Model state: remaining guard cycles, request/load phase flags, a pending slot check,
  // and the boot_i values sampled at the last three clock edges.
  int         g_left = GUARD;
  bit         in_req = 1'b0;
  bit         in_load = 1'b0;
  bit         arm = 1'b0;
  logic [3:0] m_slot = '0;
  logic [3:0] m_last = '0;
  bit         m_err = 1'b0;
  bit         h1 = 1'b0;
  bit         h2 = 1'b0;
  bit         h3 = 1'b0;

  // Behavioural model.
  // A request is seen when boot_i was high two edges ago and low three edges ago,
  // but only while the controller is idle.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      g_left = GUARD; in_req = 1'b0; in_load = 1'b0; arm = 1'b0;
      m_slot = '0; m_last = '0; m_err = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    end else begin
      if (g_left > 0) begin
        g_left = g_left - 1;
      end else if (in_req) begin
        if (cfg_ack_i) begin
          in_req = 1'b0; in_load = 1'b1;
        end
      end else if (in_load) begin
        if (cfg_err_i) begin
          m_err = 1'b1; in_load = 1'b0; g_left = GUARD;
        end else if (cfg_done_i) begin
          m_last = m_slot; in_load = 1'b0; g_left = GUARD;
        end
      end else if (arm) begin
        arm = 1'b0;
        if (int'(m_slot) >= NUM_SLOTS) m_err = 1'b1;
        else in_req = 1'b1;
      end else if (h2 && !h3) begin
        m_slot = slot_i; arm = 1'b1;
      end
      h3 = h2; h2 = h1; h1 = boot_i;
    end
  end

  // Compare every DUT output against the model on each falling edge out of reset.
  initial forever begin
    @(negedge clk);
    if (rst_n && !sim_done) begin
      checkOutput("model_fabric_reset", 32'(fabric_reset_o), 32'(g_left > 0 || in_req || in_load));
      checkOutput("model_busy", 32'(busy_o), 32'(g_left > 0 || in_req || in_load));
      checkOutput("model_cfg_req", 32'(cfg_req_o), 32'(in_req));
      checkOutput("model_cfg_addr", 32'(cfg_addr_o),
                  in_req ? ((32'(m_slot) << SHIFT) & ((32'd1 << ADDR_W) - 32'd1)) : 32'd0);
      checkOutput("model_last_slot", 32'(last_slot_o), 32'(m_last));
      checkOutput("model_err", 32'(err_o), 32'(m_err));
`ifdef WARMBOOT_TIMEOUT_EN
      checkOutput("model_timeout", 32'(timeout_o), 32'd0);
`endif
    end
  end

  // One comparison: count it and report any disagreement.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Drive every DUT input at once.
  task automatic applyStimulus(input logic boot, input logic [3:0] slot,
                               input logic ack, input logic done, input logic err);
    boot_i = boot; slot_i = slot; cfg_ack_i = ack; cfg_done_i = done; cfg_err_i = err;
  endtask

  // Advance n clocks, leaving time just after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Present a slot, raise boot_i and expect the load request exactly 4 clocks later.
  task automatic requestSlot(input logic [3:0] slot, input bit hold, input logic [31:0] exp_addr);
    applyStimulus(1'b0, slot, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(1'b1, slot, 1'b0, 1'b0, 1'b0);
    tick(1);
    if (!hold) applyStimulus(1'b0, slot, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("req_before_latency", 32'(cfg_req_o), 32'd0);
    tick(1);
    checkOutput("req_at_latency", 32'(cfg_req_o), 32'd1);
    checkOutput("req_addr", 32'(cfg_addr_o), exp_addr);
    checkOutput("fabric_reset_with_req", 32'(fabric_reset_o), 32'd1);
  endtask

  // Present an out-of-range slot: no request, error flagged, fabric left running.
  task automatic rejectSlot(input logic [3:0] slot);
    applyStimulus(1'b0, slot, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(1'b1, slot, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, slot, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("reject_err", 32'(err_o), 32'd1);
    checkOutput("reject_no_req", 32'(cfg_req_o), 32'd0);
    checkOutput("reject_fabric_running", 32'(fabric_reset_o), 32'd0);
    checkOutput("reject_not_busy", 32'(busy_o), 32'd0);
  endtask

  // Acknowledge after ack_wait clocks, then end the load after load_wait more.
  task automatic finishLoad(input int ack_wait, input int load_wait, input logic done, input logic err);
    tick(ack_wait);
    checkOutput("req_held_until_ack", 32'(cfg_req_o), 32'd1);
    applyStimulus(boot_i, slot_i, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(boot_i, slot_i, 1'b0, 1'b0, 1'b0);
    checkOutput("req_drops_after_ack", 32'(cfg_req_o), 32'd0);
    tick(load_wait);
    applyStimulus(boot_i, slot_i, 1'b0, done, err);
    tick(1);
    applyStimulus(boot_i, slot_i, 1'b0, 1'b0, 1'b0);
    checkOutput("guard_after_load", 32'(fabric_reset_o), 32'd1);
  endtask

  // From the first guard cycle: 15 more in guard, then idle with the fabric released.
  task automatic guardThenIdle();
    tick(15);
    checkOutput("guard_last_cycle", 32'(fabric_reset_o), 32'd1);
    tick(1);
    checkOutput("guard_released", 32'(fabric_reset_o), 32'd0);
    checkOutput("idle_not_busy", 32'(busy_o), 32'd0);
  endtask

  // Directed scenario sequence.
  initial begin
    int hi;
    int reqs;
    hi = 0;
    reqs = 0;
    $display("[TB] warmboot_ctrl directed run");

    tick(2);
    checkOutput("rst_fabric_reset", 32'(fabric_reset_o), 32'd1);
    checkOutput("rst_busy", 32'(busy_o), 32'd1);
    checkOutput("rst_cfg_req", 32'(cfg_req_o), 32'd0);
    checkOutput("rst_cfg_addr", 32'(cfg_addr_o), 32'd0);
    checkOutput("rst_last_slot", 32'(last_slot_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    rst_n = 1'b1;

    repeat (20) begin
      @(negedge clk);
      if (fabric_reset_o) hi++;
      if (cfg_req_o) reqs++;
    end
    tick(1);
    checkOutput("guard_len_after_reset", 32'(hi), 32'd16);
    checkOutput("no_req_during_guard", 32'(reqs), 32'd0);
    checkOutput("idle_after_reset_guard", 32'(busy_o), 32'd0);

    requestSlot(4'd3, 1'b0, 32'h000C0000);
    finishLoad(4, 19, 1'b1, 1'b0);
    checkOutput("slot3_last_slot", 32'(last_slot_o), 32'd3);
    checkOutput("slot3_no_err", 32'(err_o), 32'd0);
    guardThenIdle();

    applyStimulus(1'b0, 4'd3, 1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("idle_ignores_err", 32'(err_o), 32'd0);
    checkOutput("idle_ignores_ack", 32'(cfg_req_o), 32'd0);

    requestSlot(4'd5, 1'b1, 32'h00140000);
    finishLoad(2, 3, 1'b1, 1'b0);
    guardThenIdle();
    tick(10);
    checkOutput("held_no_retrigger", 32'(cfg_req_o), 32'd0);
    checkOutput("held_last_slot", 32'(last_slot_o), 32'd5);
    requestSlot(4'd5, 1'b1, 32'h00140000);
    finishLoad(0, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    guardThenIdle();

    requestSlot(4'd7, 1'b0, 32'h001C0000);
    finishLoad(1, 1, 1'b1, 1'b0);
    guardThenIdle();
    checkOutput("top_slot_last", 32'(last_slot_o), 32'd7);

    rejectSlot(4'd8);
    checkOutput("reject8_last_unchanged", 32'(last_slot_o), 32'd7);

    requestSlot(4'd1, 1'b0, 32'h00040000);
    applyStimulus(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(3);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_fabric_reset", 32'(fabric_reset_o), 32'd1);
    checkOutput("async_rst_busy", 32'(busy_o), 32'd1);
    checkOutput("async_rst_cfg_req", 32'(cfg_req_o), 32'd0);
    checkOutput("async_rst_cfg_addr", 32'(cfg_addr_o), 32'd0);
    checkOutput("async_rst_last_slot", 32'(last_slot_o), 32'd0);
    checkOutput("async_rst_err", 32'(err_o), 32'd0);
    tick(2);
    rst_n = 1'b1;
    guardThenIdle();

    requestSlot(4'd6, 1'b0, 32'h00180000);
    finishLoad(1, 1, 1'b1, 1'b0);
    guardThenIdle();
    requestSlot(4'd2, 1'b0, 32'h00080000);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    finishLoad(1, 2, 1'b1, 1'b1);
    checkOutput("loader_err_flag", 32'(err_o), 32'd1);
    checkOutput("loader_err_last_unchanged", 32'(last_slot_o), 32'd6);
    guardThenIdle();
    tick(6);
    checkOutput("busy_boot_not_queued", 32'(cfg_req_o), 32'd0);

    rejectSlot(4'd12);
    checkOutput("reject12_last_unchanged", 32'(last_slot_o), 32'd6);

    sim_done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
